nanorv32_ascii_trace: RTL and testbench
=======================================

// Module: nanorv32_ascii_trace
// PURPOSE
//  Registered RV32IM disassembler for simulation trace and debug.
//  - Turns the retired instruction word into a 6-char ASCII mnemonic.
//  - Turns the three register indices into 4-char ASCII register names.
//  - Sits beside the nanorv32 core and feeds a $fwrite trace line: "PC : I : <mnem> <rd>, <rs1>, <rs2>".
// PARAMETERS
//  PAD_CHAR   8'h20  fill byte used for unused character positions
//  UNK_MNEM   "???"  mnemonic text for an unrecognised encoding, left-justified and padded
// PORTS
//  clk               in   1   the single clock; all state updates on posedge clk
//  rst               in   1   reset, synchronous, active-high
//  instruction_r     in   32  instruction word currently in execute
//  reg_rd            in   5   destination register index
//  reg_rs1           in   5   source register 1 index
//  reg_rs2           in   5   source register 2 index
//  ascii_chain       out  48  mnemonic, 6 chars; [47:40] is the first char
//  reg_to_ascii_rd   out  32  rd name, 4 chars; [31:24] is the first char
//  reg_to_ascii_rs1  out  32  rs1 name, 4 chars
//  reg_to_ascii_rs2  out  32  rs2 name, 4 chars
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: while rst=1 at posedge clk, every output byte loads PAD_CHAR (all 0x20).
//  - Latency: outputs are registered. Inputs sampled at edge N appear after edge N; one cycle latency, no handshake.
//  - The next-state decode is purely combinational from the inputs.
//  - Text format: all text is left-justified and padded with PAD_CHAR to full width. No NUL bytes.
//  - Decode key: opcode[6:0], funct3[14:12], funct7[31:25].
//    - 0110111 lui; 0010111 auipc; 1101111 jal; 1100111 jalr (funct3=0 only).
//    - 1100011: beq,bne,-,-,blt,bge,bltu,bgeu (funct3 0..7); 2 and 3 are unknown.
//    - 0000011: lb,lh,lw,-,lbu,lhu (funct3 0,1,2,4,5).
//    - 0100011: sb,sh,sw (funct3 0..2).
//    - 0010011: addi,slli,slti,sltiu,xori,srli|srai,ori,andi.
//      - srli when funct7=0000000; srai when funct7=0100000.
//      - slli requires funct7=0000000.
//    - 0110011, funct7=0000000: add,sll,slt,sltu,xor,srl,or,and.
//    - 0110011, funct7=0100000: sub (f3=0), sra (f3=5).
//    - 0110011, funct7=0000001: mul,mulh,mulhsu,mulhu,div,divu,rem,remu.
//    - 0001111 fence.
//    - 1110011, funct3=0: instruction 0x00000073 is ecall; 0x00100073 is ebreak.
//    - 1110011, funct3 1,2,3,5,6,7: csrrw,csrrs,csrrc,csrrwi,csrrsi,csrrci.
//    - Any other encoding, including bits[1:0] not equal to 2'b11, gives UNK_MNEM.
//  - Register names: index n maps to "x<n>" in decimal, e.g. "x0  ", "x31 ".
//    - Names always derive from the reg_* ports, never from instruction fields.
//    - Unused operands are still rendered.
//  - Boundaries:
//    - Index 0 and index 31 are both valid.
//    - X or Z on any input gives UNK_MNEM and "????" names; outputs never go X after reset.
//    - rst asserted mid-stream overrides the input sample on that edge.
// CONFIGURATION
//  NANORV32_ASCII_ABI_NAMES_EN
//  - Defined: registers print as ABI names: zero,ra,sp,gp,tp,t0-t2,s0,s1,a0-a7,s2-s11,t3-t6. Example: index 10 is "a0  ".
//  - Undefined: registers print as numeric "x<n>" names.
//  - Mnemonic decode is identical in both builds.
// TESTING
//  1. rst=1 for 2 edges -> all four outputs all 0x20; release -> decode of the inputs appears 1 edge later.
//  2. instr 0x00a50533, rd=rs1=rs2=10 -> "add   ", "x10 " x3 (ABI build: "a0  ").
//  3. 0x40b50533 -> "sub   "; 0x02b50533 -> "mul   "; 0x4015d593 -> "srai  ".
//  4. 0x00000073 -> "ecall "; 0x00100073 -> "ebreak"; 0x00000013 with rd=0 -> "addi  ", "x0  " (ABI build: "zero").
//  5. 0xFFFFFFFF and 0x00002063 -> "???   "; instruction driven to X -> "???   " and names "????".
//  6. Index sweep 0..31 on reg_rd -> "x0  ".."x31 " in order. Raising rst mid-sweep -> 0x20 bytes on that edge.

Source files
------------

// File: rtl/nanorv32_ascii_trace.sv
// Registered RV32IM disassembler: ASCII mnemonic plus three register names.
// Define NANORV32_ASCII_ABI_NAMES_EN to print ABI register names instead of x<n>.
module nanorv32_ascii_trace #(
  parameter logic [7:0]  PAD_CHAR = 8'h20,
  parameter logic [47:0] UNK_MNEM = "???"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_r,
  input  logic [4:0]  reg_rd,
  input  logic [4:0]  reg_rs1,
  input  logic [4:0]  reg_rs2,
  output logic [47:0] ascii_chain,
  output logic [31:0] reg_to_ascii_rd,
  output logic [31:0] reg_to_ascii_rs1,
  output logic [31:0] reg_to_ascii_rs2
);

  localparam logic [47:0] PAD6 = {6{PAD_CHAR}};
  localparam logic [31:0] PAD4 = {4{PAD_CHAR}};
  localparam logic [31:0] UNK4 = "????";

  // Literals are right-aligned with NUL fill; move text to the top and pad.
  function automatic logic [47:0] just6(input logic [47:0] s);
    logic [47:0] r;
    r = s;
    for (int k = 0; k < 6; k++) begin
      if (r[47:40] == 8'h00) r = {r[39:0], PAD_CHAR};
    end
    return r;
  endfunction

  function automatic logic [31:0] just4(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int k = 0; k < 4; k++) begin
      if (r[31:24] == 8'h00) r = {r[23:0], PAD_CHAR};
    end
    return r;
  endfunction

  function automatic logic [31:0] reg_name(input logic [4:0] n);
    logic [31:0] s;
`ifdef NANORV32_ASCII_ABI_NAMES_EN
    case (n)
      5'd0:  s = "zero";
      5'd1:  s = "ra";
      5'd2:  s = "sp";
      5'd3:  s = "gp";
      5'd4:  s = "tp";
      5'd5:  s = "t0";
      5'd6:  s = "t1";
      5'd7:  s = "t2";
      5'd8:  s = "s0";
      5'd9:  s = "s1";
      5'd10: s = "a0";
      5'd11: s = "a1";
      5'd12: s = "a2";
      5'd13: s = "a3";
      5'd14: s = "a4";
      5'd15: s = "a5";
      5'd16: s = "a6";
      5'd17: s = "a7";
      5'd18: s = "s2";
      5'd19: s = "s3";
      5'd20: s = "s4";
      5'd21: s = "s5";
      5'd22: s = "s6";
      5'd23: s = "s7";
      5'd24: s = "s8";
      5'd25: s = "s9";
      5'd26: s = "s10";
      5'd27: s = "s11";
      5'd28: s = "t3";
      5'd29: s = "t4";
      5'd30: s = "t5";
      default: s = "t6";
    endcase
`else
    logic [4:0] tens;
    logic [4:0] ones;
    tens = n / 5'd10;
    ones = n % 5'd10;
    if (n < 5'd10)
      s = {16'h0000, "x", 8'h30 + {3'b000, ones}};
    else
      s = {8'h00, "x", 8'h30 + {3'b000, tens}, 8'h30 + {3'b000, ones}};
`endif
    return just4(s);
  endfunction

  function automatic logic [47:0] mnem(input logic [31:0] i);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [47:0] m;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    m  = UNK_MNEM;
    case (op)
      7'b0110111: m = "lui";
      7'b0010111: m = "auipc";
      7'b1101111: m = "jal";
      7'b1100111: if (f3 == 3'd0) m = "jalr";
      7'b1100011:
        case (f3)
          3'd0: m = "beq";
          3'd1: m = "bne";
          3'd4: m = "blt";
          3'd5: m = "bge";
          3'd6: m = "bltu";
          3'd7: m = "bgeu";
          default: m = UNK_MNEM;
        endcase
      7'b0000011:
        case (f3)
          3'd0: m = "lb";
          3'd1: m = "lh";
          3'd2: m = "lw";
          3'd4: m = "lbu";
          3'd5: m = "lhu";
          default: m = UNK_MNEM;
        endcase
      7'b0100011:
        case (f3)
          3'd0: m = "sb";
          3'd1: m = "sh";
          3'd2: m = "sw";
          default: m = UNK_MNEM;
        endcase
      7'b0010011:
        case (f3)
          3'd0: m = "addi";
          3'd1: if (f7 == 7'b0000000) m = "slli";
          3'd2: m = "slti";
          3'd3: m = "sltiu";
          3'd4: m = "xori";
          3'd5:
            if (f7 == 7'b0000000) m = "srli";
            else if (f7 == 7'b0100000) m = "srai";
          3'd6: m = "ori";
          default: m = "andi";
        endcase
      7'b0110011:
        case (f7)
          7'b0000000:
            case (f3)
              3'd0: m = "add";
              3'd1: m = "sll";
              3'd2: m = "slt";
              3'd3: m = "sltu";
              3'd4: m = "xor";
              3'd5: m = "srl";
              3'd6: m = "or";
              default: m = "and";
            endcase
          7'b0100000:
            if (f3 == 3'd0) m = "sub";
            else if (f3 == 3'd5) m = "sra";
          7'b0000001:
            case (f3)
              3'd0: m = "mul";
              3'd1: m = "mulh";
              3'd2: m = "mulhsu";
              3'd3: m = "mulhu";
              3'd4: m = "div";
              3'd5: m = "divu";
              3'd6: m = "rem";
              default: m = "remu";
            endcase
          default: m = UNK_MNEM;
        endcase
      7'b0001111: m = "fence";
      7'b1110011:
        case (f3)
          3'd0:
            if (i == 32'h0000_0073) m = "ecall";
            else if (i == 32'h0010_0073) m = "ebreak";
          3'd1: m = "csrrw";
          3'd2: m = "csrrs";
          3'd3: m = "csrrc";
          3'd5: m = "csrrwi";
          3'd6: m = "csrrsi";
          3'd7: m = "csrrci";
          default: m = UNK_MNEM;
        endcase
      default: m = UNK_MNEM;
    endcase
    return just6(m);
  endfunction

  logic        in_x;
  logic [47:0] nxt_mnem;
  logic [31:0] nxt_rd;
  logic [31:0] nxt_rs1;
  logic [31:0] nxt_rs2;

  // Unknown-input detection only has meaning in a four-state simulator.
`ifdef SYNTHESIS
  assign in_x = 1'b0;
`else
  assign in_x = $isunknown({instruction_r, reg_rd, reg_rs1, reg_rs2});
`endif

  always_comb begin
    nxt_mnem = just6(UNK_MNEM);
    nxt_rd   = UNK4;
    nxt_rs1  = UNK4;
    nxt_rs2  = UNK4;
    if (!in_x) begin
      nxt_mnem = mnem(instruction_r);
      nxt_rd   = reg_name(reg_rd);
      nxt_rs1  = reg_name(reg_rs1);
      nxt_rs2  = reg_name(reg_rs2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ascii_chain      <= PAD6;
      reg_to_ascii_rd  <= PAD4;
      reg_to_ascii_rs1 <= PAD4;
      reg_to_ascii_rs2 <= PAD4;
    end else begin
      ascii_chain      <= nxt_mnem;
      reg_to_ascii_rd  <= nxt_rd;
      reg_to_ascii_rs1 <= nxt_rs1;
      reg_to_ascii_rs2 <= nxt_rs2;
    end
  end

endmodule

// File: tb/tb_nanorv32_ascii_trace.sv
// Self-checking bench for nanorv32_ascii_trace.
// Table vectors, reset/sweep sequences and a string-based random reference.
module tb_nanorv32_ascii_trace;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_r;
  logic [4:0]  reg_rd;
  logic [4:0]  reg_rs1;
  logic [4:0]  reg_rs2;
  logic [47:0] ascii_chain;
  logic [31:0] reg_to_ascii_rd;
  logic [31:0] reg_to_ascii_rs1;
  logic [31:0] reg_to_ascii_rs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nanorv32_ascii_trace dut (
    .clk(clk),
    .rst(rst),
    .instruction_r(instruction_r),
    .reg_rd(reg_rd),
    .reg_rs1(reg_rs1),
    .reg_rs2(reg_rs2),
    .ascii_chain(ascii_chain),
    .reg_to_ascii_rd(reg_to_ascii_rd),
    .reg_to_ascii_rs1(reg_to_ascii_rs1),
    .reg_to_ascii_rs2(reg_to_ascii_rs2)
  );

  string br_t[8]  = '{"beq", "bne", "", "", "blt", "bge", "bltu", "bgeu"};
  string ld_t[8]  = '{"lb", "lh", "lw", "", "lbu", "lhu", "", ""};
  string st_t[8]  = '{"sb", "sh", "sw", "", "", "", "", ""};
  string imm_t[8] = '{"addi", "", "slti", "sltiu", "xori", "", "ori", "andi"};
  string rr_t[8]  = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
  string md_t[8]  = '{"mul", "mulh", "mulhsu", "mulhu",
                      "div", "divu", "rem", "remu"};
  string csr_t[8] = '{"", "csrrw", "csrrs", "csrrc",
                      "", "csrrwi", "csrrsi", "csrrci"};
  string abi_t[32] = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
                       "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
                       "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
                       "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};

  function automatic string ref_mnem(bit [31:0] i);
    bit [6:0] op = i[6:0];
    bit [2:0] f3 = i[14:12];
    bit [6:0] f7 = i[31:25];
    string s = "";
    case (op)
      7'h37: s = "lui";
      7'h17: s = "auipc";
      7'h6f: s = "jal";
      7'h67: s = (f3 == 0) ? "jalr" : "";
      7'h63: s = br_t[f3];
      7'h03: s = ld_t[f3];
      7'h23: s = st_t[f3];
      7'h13:
        if (f3 == 1) s = (f7 == 0) ? "slli" : "";
        else if (f3 == 5)
          s = (f7 == 0) ? "srli" : (f7 == 7'h20) ? "srai" : "";
        else s = imm_t[f3];
      7'h33:
        if (f7 == 0) s = rr_t[f3];
        else if (f7 == 7'h20)
          s = (f3 == 0) ? "sub" : (f3 == 5) ? "sra" : "";
        else if (f7 == 7'h01) s = md_t[f3];
      7'h0f: s = "fence";
      7'h73:
        if (i == 32'h73) s = "ecall";
        else if (i == 32'h100073) s = "ebreak";
        else if (f3 != 0) s = csr_t[f3];
      default: s = "";
    endcase
    return (s == "") ? "???" : s;
  endfunction

  function automatic string ref_reg(int n);
`ifdef NANORV32_ASCII_ABI_NAMES_EN
    return abi_t[n];
`else
    return $sformatf("x%0d", n);
`endif
  endfunction

  function automatic logic [47:0] txt6(string s);
    logic [47:0] r;
    for (int k = 0; k < 6; k++)
      r[47-8*k -: 8] = (k < s.len()) ? s[k] : 8'h20;
    return r;
  endfunction

  function automatic logic [31:0] txt4(string s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[31-8*k -: 8] = (k < s.len()) ? s[k] : 8'h20;
    return r;
  endfunction

  task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, " mnem"}, ascii_chain, txt6(ref_mnem(instruction_r)));
    chk({tag, " rd"}, {16'h0, reg_to_ascii_rd}, {16'h0, txt4(ref_reg(reg_rd))});
    chk({tag, " rs1"}, {16'h0, reg_to_ascii_rs1}, {16'h0, txt4(ref_reg(reg_rs1))});
    chk({tag, " rs2"}, {16'h0, reg_to_ascii_rs2}, {16'h0, txt4(ref_reg(reg_rs2))});
  endtask

  task automatic chk_pad(string tag);
    chk({tag, " mnem"}, ascii_chain, 48'h202020202020);
    chk({tag, " rd"}, {16'h0, reg_to_ascii_rd}, 48'h20202020);
    chk({tag, " rs1"}, {16'h0, reg_to_ascii_rs1}, 48'h20202020);
    chk({tag, " rs2"}, {16'h0, reg_to_ascii_rs2}, 48'h20202020);
  endtask

`ifdef NANORV32_ASCII_ABI_NAMES_EN
  localparam logic [31:0] N0 = "zero";
  localparam logic [31:0] N10 = "a0  ";
  localparam logic [31:0] N31 = "t6  ";
`else
  localparam logic [31:0] N0 = "x0  ";
  localparam logic [31:0] N10 = "x10 ";
  localparam logic [31:0] N31 = "x31 ";
`endif

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [47:0] mnem;
    logic [31:0] rdn;
  } vec_t;

  vec_t tbl[12];
  bit [6:0] ops[11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                        7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};

  initial begin
    tbl[0]  = '{32'h00a50533, 5'd10, "add   ", N10};
    tbl[1]  = '{32'h40b50533, 5'd10, "sub   ", N10};
    tbl[2]  = '{32'h02b50533, 5'd10, "mul   ", N10};
    tbl[3]  = '{32'h4015d593, 5'd31, "srai  ", N31};
    tbl[4]  = '{32'h00000073, 5'd0,  "ecall ", N0};
    tbl[5]  = '{32'h00100073, 5'd0,  "ebreak", N0};
    tbl[6]  = '{32'h00000013, 5'd0,  "addi  ", N0};
    tbl[7]  = '{32'hffffffff, 5'd31, "???   ", N31};
    tbl[8]  = '{32'h00002063, 5'd10, "???   ", N10};
    tbl[9]  = '{32'h000000b7, 5'd1,  "lui   ", 32'h0};
    tbl[10] = '{32'h0200d033, 5'd10, "divu  ", N10};
    tbl[11] = '{32'h00001073, 5'd0,  "csrrw ", N0};

    rst = 1'b1;
    instruction_r = 32'h00a50533;
    reg_rd = 5'd10;
    reg_rs1 = 5'd10;
    reg_rs2 = 5'd10;
    step();
    step();
    chk_pad("reset");
    rst = 1'b0;
    step();
    chk("post-reset mnem", ascii_chain, "add   ");
    chk("post-reset rd", {16'h0, reg_to_ascii_rd}, {16'h0, N10});

    for (int t = 0; t < 12; t++) begin
      instruction_r = tbl[t].ins;
      reg_rd = tbl[t].rd;
      reg_rs1 = tbl[t].rd;
      reg_rs2 = 5'(t);
      step();
      chk($sformatf("tbl%0d mnem", t), ascii_chain, tbl[t].mnem);
      if (tbl[t].rdn != 32'h0)
        chk($sformatf("tbl%0d rd", t), {16'h0, reg_to_ascii_rd},
            {16'h0, tbl[t].rdn});
      chk_model($sformatf("tbl%0d", t));
    end

    instruction_r = 'x;
    step();
    chk("xinstr mnem", ascii_chain, "???   ");

    instruction_r = 32'h00a50533;
    for (int n = 0; n < 32; n++) begin
      reg_rd = 5'(n);
      reg_rs1 = 5'(31 - n);
      reg_rs2 = 5'(n ^ 5);
      if (n == 16) begin
        rst = 1'b1;
        step();
        chk_pad("mid-sweep reset");
        rst = 1'b0;
      end
      step();
      chk($sformatf("sweep%0d rd", n), {16'h0, reg_to_ascii_rd},
          {16'h0, txt4(ref_reg(n))});
      chk_model($sformatf("sweep%0d", n));
    end

    for (int r = 0; r < 400; r++) begin
      bit [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        w[6:0] = ops[$urandom_range(0, 10)];
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
        if (w[6:0] == 7'h73 && $urandom_range(0, 3) == 0)
          w = $urandom_range(0, 1) ? 32'h00100073 : 32'h00000073;
      end
      instruction_r = w;
      reg_rd = 5'($urandom);
      reg_rs1 = 5'($urandom);
      reg_rs2 = 5'($urandom);
      step();
      chk_model($sformatf("rand%0d %h", r, w));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
